mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 mem_read_in  input  1  load op currently held in the EX/MEM stage.
REQ-004 mem_write_in  input  1  store op currently held in the EX/MEM stage.
REQ-005 funct3_in  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 alu_addr_in  input  32  effective byte address (EX/MEM ALU result).
REQ-007 rs2_data_in  input  32  store data (EX/MEM rs2 data).
REQ-008 advance_in  input  1  pipeline register load enable, high when EX/MEM/WB advance this cycle.
REQ-009 data_read  output  1  dcache read request.
REQ-010 data_write  output  1  dcache write request.
REQ-011 data_addr  output  32  word-aligned dcache address.
REQ-012 data_mbe  output  4  dcache byte enables.
REQ-013 data_wdata  output  32  dcache write data.
REQ-014 data_rdata  input  32  dcache read data, valid with data_resp.
REQ-015 data_resp  input  1  dcache one-cycle completion pulse.
REQ-016 mem_stall  output  1  pipeline must hold all stages while high.
REQ-017 load_data_out  output  32  aligned, extended load result for MEM/WB.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE with (mem_read_in | mem_write_in): go to BUSY.
- IDLE otherwise: stay.
- BUSY with data_resp: go to DONE.
- BUSY otherwise: stay.
- DONE with advance_in: go to IDLE.
- DONE otherwise: stay.
REQ-019 data_read/data_write SHALL be asserted combinationally in IDLE when an op is present and throughout BUSY; deasserted in DONE.
REQ-020 If mem_read_in and mem_write_in are both high, the op SHALL be treated as a store only (data_read=0).
REQ-021 mem_stall SHALL be 1 in IDLE-with-op and in BUSY (including the data_resp cycle), and 0 in DONE and in IDLE with no op.
REQ-022 Minimum latency SHALL be: request cycle N; data_resp no earlier than N; DONE and mem_stall=0 at resp+1.
REQ-023 data_addr SHALL be {alu_addr_in[31:2], 2'b00}; off = alu_addr_in[1:0].
REQ-024 Byte enables SHALL be:
- stores: B 0001<<off; H 0011<<{off[1],0}; W 1111 (off ignored).
- loads: 1111.
REQ-025 data_wdata SHALL be: B {4{rs2[7:0]}}; H {2{rs2[15:0]}}; W rs2.
REQ-026 On data_resp for a load, a 32-bit register SHALL capture the extracted data:
- B: sign-extended byte at off.
- BU: zero-extended byte at off.
- H: sign-extended half at off[1].
- HU: zero-extended half at off[1].
- W: full word.
REQ-027 For a store, the captured data SHALL be 0.
REQ-028 load_data_out SHALL equal the capture register at all times; it is held through DONE until the next data_resp.
REQ-029 Unsupported funct3 SHALL be handled as W.
REQ-030 Inputs SHALL be sampled continuously; the upstream guarantees they are stable while mem_stall=1.
REQ-031 An op SHALL issue exactly once: DONE blocks re-issue while advance_in=0.

Reset
REQ-032 On rst the FSM SHALL enter IDLE and load_data_out SHALL become 0, from any state including BUSY.
REQ-033 After a reset in BUSY, a late data_resp SHALL be ignored and the register SHALL keep 0.

Verification
REQ-034 LW, addr 0x100, resp after 3 cycles, rdata 0xDEADBEEF -> data_read=1 for 4 cycles, mem_stall=1 for 4 cycles then 0, load_data_out=0xDEADBEEF in DONE.
REQ-035 LB/LBU, addr 0x103, rdata 0x80000000 -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
REQ-036 SH, addr 0x202, rs2 0x1234ABCD -> data_addr 0x200, mbe 1100, wdata 0xABCDABCD, data_write deasserts in DONE.
REQ-037 Load completes with advance_in=0 for 3 cycles -> DONE held, no second data_read, mem_stall=0.
REQ-038 rst asserted in BUSY, then data_resp -> IDLE, load_data_out=0, no request unless an op is present.
REQ-039 Back-to-back SW then LW, each resp at 0 wait -> each request 1 cycle, DONE 1 cycle each, total 4 cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store interface between the EX/MEM stage and the data cache.
// Issues a single dcache request per op, stalls the pipeline until the response, and aligns/extends load data.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_addr_in,
    input  logic [31:0] rs2_data_in,
    input  logic        advance_in,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_addr,
    output logic [3:0]  data_mbe,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_resp,
    output logic        mem_stall,
    output logic [31:0] load_data_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        op_present;
    logic        is_load;
    logic        requesting;
    logic        accept;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] load_reg;

    assign op_present = mem_read_in | mem_write_in;
    // A simultaneous read+write is a store only.
    assign is_load    = mem_read_in & ~mem_write_in;
    assign requesting = ((state == IDLE) && op_present) || (state == BUSY);
    assign accept     = requesting && data_resp;
    assign off        = alu_addr_in[1:0];

    assign data_read     = requesting & is_load;
    assign data_write    = requesting & mem_write_in;
    assign mem_stall     = requesting;
    assign data_addr     = {alu_addr_in[31:2], 2'b00};
    assign load_data_out = load_reg;

    // A zero-wait response in the request cycle goes straight to DONE so the op still takes one stall cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (op_present) state_next = data_resp ? DONE : BUSY;
            BUSY: if (data_resp) state_next = DONE;
            DONE: if (advance_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_mbe   = 4'b1111;
        data_wdata = rs2_data_in;
        case (funct3_in)
            F3_B: begin
                data_wdata = {4{rs2_data_in[7:0]}};
                if (mem_write_in) data_mbe = 4'b0001 << off;
            end
            F3_H: begin
                data_wdata = {2{rs2_data_in[15:0]}};
                if (mem_write_in) data_mbe = 4'b0011 << {off[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off)
            2'd0:    byte_sel = data_rdata[7:0];
            2'd1:    byte_sel = data_rdata[15:8];
            2'd2:    byte_sel = data_rdata[23:16];
            default: byte_sel = data_rdata[31:24];
        endcase
        half_sel = off[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (funct3_in)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'd0, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'd0, half_sel};
            default: load_ext = data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            load_reg <= '0;
        end else begin
            state <= state_next;
            if (accept) load_reg <= is_load ? load_ext : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized ops against a transaction-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_addr_in, rs2_data_in;
    logic        advance_in;
    logic        data_read, data_write;
    logic [31:0] data_addr;
    logic [3:0]  data_mbe;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        mem_stall;
    logic [31:0] load_data_out;

    int          tests = 0;
    int          fails = 0;
    int          cyc_count = 0;
    logic [31:0] exp_ldo = '0;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .funct3_in(funct3_in), .alu_addr_in(alu_addr_in), .rs2_data_in(rs2_data_in),
        .advance_in(advance_in),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_mbe(data_mbe), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_resp(data_resp),
        .mem_stall(mem_stall), .load_data_out(load_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    task automatic idle_inputs();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        data_resp    = 1'b0;
        advance_in   = 1'b1;
    endtask

    // One op: lat non-responding request cycles, then the response cycle, then hold+1 DONE cycles.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int unsigned lat, input int unsigned hold, input string tag);
        logic        exp_rd;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_wd, exp_cap;
        exp_rd  = rd & ~wr;
        exp_mbe = 4'hF;
        exp_wd  = rs2;
        if (wr && f3 == 3'b000) begin
            exp_mbe = 4'(1 << addr[1:0]);
            exp_wd  = rs2[7:0] * 32'h01010101;
        end else if (wr && f3 == 3'b001) begin
            exp_mbe = 4'(3 << (addr[1:0] & 2'b10));
            exp_wd  = rs2[15:0] * 32'h00010001;
        end
        exp_cap = exp_rd ? ref_load(f3, addr[1:0], rdata) : 32'd0;
        for (int unsigned c = 0; c <= lat; c++) begin
            @(negedge clk);
            mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
            alu_addr_in = addr; rs2_data_in = rs2; advance_in = 1'b0;
            data_resp = (c == lat);
            data_rdata = (c == lat) ? rdata : $urandom;
            #1;
            tests++;
            if ({data_read, data_write, mem_stall, data_addr} !== {exp_rd, wr, 1'b1, addr & 32'hFFFF_FFFC}) begin
                fails++;
                $display("FAIL %s req c%0d: got rd/wr/stall/addr %b%b%b/%h exp %b%b%b/%h", tag, c,
                         data_read, data_write, mem_stall, data_addr, exp_rd, wr, 1'b1, addr & 32'hFFFF_FFFC);
            end
            tests++;
            if (data_mbe !== exp_mbe) begin
                fails++;
                $display("FAIL %s mbe c%0d: got %b exp %b", tag, c, data_mbe, exp_mbe);
            end
            if (wr) begin
                tests++;
                if (data_wdata !== exp_wd) begin
                    fails++;
                    $display("FAIL %s wdata c%0d: got %h exp %h", tag, c, data_wdata, exp_wd);
                end
            end
            tests++;
            if (load_data_out !== exp_ldo) begin
                fails++;
                $display("FAIL %s ldo_hold c%0d: got %h exp %h", tag, c, load_data_out, exp_ldo);
            end
            cyc_count++;
        end
        exp_ldo = exp_cap;
        for (int unsigned h = 0; h <= hold; h++) begin
            @(negedge clk);
            data_resp  = 1'b0;
            advance_in = (h == hold);
            #1;
            tests++;
            if ({data_read, data_write, mem_stall} !== 3'b000 || load_data_out !== exp_ldo) begin
                fails++;
                $display("FAIL %s done h%0d: got rd/wr/stall/ldo %b%b%b/%h exp 000/%h", tag, h,
                         data_read, data_write, mem_stall, load_data_out, exp_ldo);
            end
            cyc_count++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        funct3_in = 3'b010; alu_addr_in = '0; rs2_data_in = '0; data_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({data_read, data_write, mem_stall, load_data_out} !== {3'b000, 32'd0}) begin
            fails++;
            $display("FAIL reset: got rd/wr/stall/ldo %b%b%b/%h exp 000/00000000",
                     data_read, data_write, mem_stall, load_data_out);
        end
        exp_ldo = '0;
    endtask

    task automatic test_directed();
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, "lw_0x100");
        tests++;
        if (exp_ldo !== 32'hDEADBEEF || load_data_out !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL lw_value: got %h exp deadbeef", load_data_out);
        end
        do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 1, 0, "lb_0x103");
        tests++;
        if (load_data_out !== 32'hFFFFFF80) begin
            fails++;
            $display("FAIL lb_value: got %h exp ffffff80", load_data_out);
        end
        do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 0, 0, "lbu_0x103");
        tests++;
        if (load_data_out !== 32'h00000080) begin
            fails++;
            $display("FAIL lbu_value: got %h exp 00000080", load_data_out);
        end
        do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 0, "sh_0x202");
        do_op(1'b1, 1'b0, 3'b011, 32'h305, 32'h0, 32'hCAFEF00D, 0, 0, "unsup_as_w");
    endtask

    task automatic test_advance_hold();
        do_op(1'b1, 1'b0, 3'b101, 32'h40A, 32'h0, 32'h9ABC1234, 1, 3, "lhu_hold3");
    endtask

    task automatic test_reset_in_busy();
        do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h55AA55AA, 0, 0, "pre_reset_lw");
        @(negedge clk);
        mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        alu_addr_in = 32'h20; data_resp = 1'b0; advance_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_read_in = 1'b0;
        data_resp = 1'b1;
        data_rdata = 32'h12345678;
        #1;
        tests++;
        if ({data_read, data_write, mem_stall, load_data_out} !== {3'b000, 32'd0}) begin
            fails++;
            $display("FAIL rst_busy: got rd/wr/stall/ldo %b%b%b/%h exp 000/00000000",
                     data_read, data_write, mem_stall, load_data_out);
        end
        @(negedge clk);
        data_resp = 1'b0;
        advance_in = 1'b1;
        #1;
        tests++;
        if ({data_read, data_write, mem_stall, load_data_out} !== {3'b000, 32'd0}) begin
            fails++;
            $display("FAIL late_resp: got rd/wr/stall/ldo %b%b%b/%h exp 000/00000000",
                     data_read, data_write, mem_stall, load_data_out);
        end
        exp_ldo = '0;
    endtask

    task automatic test_back_to_back();
        cyc_count = 0;
        do_op(1'b0, 1'b1, 3'b010, 32'h500, 32'hA5A5F00F, 32'h0, 0, 0, "b2b_sw");
        do_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 0, 0, "b2b_lw");
        tests++;
        if (cyc_count != 4) begin
            fails++;
            $display("FAIL b2b_cycles: got %0d exp 4", cyc_count);
        end
    endtask

    task automatic test_random();
        logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        logic [1:0] kind;
        for (int i = 0; i < 60; i++) begin
            kind = 2'($urandom_range(0, 3));
            if (kind == 2'd0) begin
                @(negedge clk);
                idle_inputs();
                alu_addr_in = $urandom;
                #1;
                tests++;
                if ({data_read, data_write, mem_stall} !== 3'b000 || load_data_out !== exp_ldo) begin
                    fails++;
                    $display("FAIL rand_idle %0d: got rd/wr/stall/ldo %b%b%b/%h exp 000/%h", i,
                             data_read, data_write, mem_stall, load_data_out, exp_ldo);
                end
            end else begin
                do_op(kind != 2'd2, kind != 2'd1, f3_tab[$urandom_range(0, 7)], $urandom, $urandom,
                      $urandom, $urandom_range(0, 4), $urandom_range(0, 2), "rand_op");
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_advance_hold();
        test_reset_in_busy();
        test_back_to_back();
        test_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
